// File: rtl/digit_classify_ctrl.sv
// rtl/digit_classify_ctrl.sv - digit recognizer sequencer: walks classes x pixels, accumulates dot products, tracks argmax
// One run per switch rising edge; the recognized digit is held on LED until the next result.
module digit_classify_ctrl #(
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_CLASSES = 10,
  parameter int PIX_AW      = 10,
  parameter int WGT_AW      = 13,
  parameter int ACC_W       = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              switch,
  output logic [PIX_AW-1:0] pix_addr,
  input  logic [7:0]        pix_data,
  output logic [WGT_AW-1:0] wgt_addr,
  input  logic [7:0]        wgt_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        LED
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE} state_t;

  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(NUM_PIXELS - 1);
  localparam logic [3:0]        CLS_LAST = 4'(NUM_CLASSES - 1);

  state_t                   state_q;
  logic                     sw_meta_q, sw_sync_q, sw_edge_q;
  logic [PIX_AW-1:0]        pix_q, pix_addr_q;
  logic [WGT_AW-1:0]        wgt_addr_q;
  logic [3:0]               class_q, best_idx_q, digit_q;
  logic signed [ACC_W-1:0]  acc_q, best_score_q;
  logic                     rd_valid_q, busy_q, done_q, valid_q;

  logic                     start_d;
  logic signed [8:0]        px_s;
  logic signed [7:0]        w_s;
  logic signed [ACC_W-1:0]  prod_d, acc_d;
  logic                     take_d;
  logic [3:0]               best_idx_d;

  assign start_d    = sw_sync_q & ~sw_edge_q;
  assign px_s       = {1'b0, pix_data};
  assign w_s        = wgt_data;
  assign prod_d     = ACC_W'(px_s) * ACC_W'(w_s);
  assign acc_d      = acc_q + prod_d;
  // Strict compare so ties keep the earlier (lower) class.
  assign take_d     = (class_q == 4'd0) || (acc_q > best_score_q);
  assign best_idx_d = take_d ? class_q : best_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sw_meta_q    <= 1'b0;
      sw_sync_q    <= 1'b0;
      sw_edge_q    <= 1'b0;
      pix_q        <= '0;
      pix_addr_q   <= '0;
      wgt_addr_q   <= '0;
      class_q      <= '0;
      best_idx_q   <= '0;
      digit_q      <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sw_meta_q  <= switch;
      sw_sync_q  <= sw_meta_q;
      sw_edge_q  <= sw_sync_q;
      done_q     <= 1'b0;
      // Memory data returns one cycle after each address issued in RUN.
      rd_valid_q <= (state_q == S_RUN);
      if (rd_valid_q) acc_q <= acc_d;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_d) begin
            class_q    <= '0;
            pix_q      <= '0;
            acc_q      <= '0;
            pix_addr_q <= '0;
            wgt_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (pix_q == PIX_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            pix_q      <= pix_q + 1'b1;
            pix_addr_q <= pix_q + 1'b1;
            wgt_addr_q <= wgt_addr_q + 1'b1;
          end
        end
        S_DRAIN: state_q <= S_CMP;
        S_CMP: begin
          if (take_d) best_score_q <= acc_q;
          best_idx_q <= best_idx_d;
          acc_q      <= '0;
          pix_q      <= '0;
          if (class_q == CLS_LAST) begin
            digit_q <= best_idx_d;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            // Weight rows are contiguous, so the next class starts one past the last address.
            class_q    <= class_q + 1'b1;
            pix_addr_q <= '0;
            wgt_addr_q <= wgt_addr_q + 1'b1;
            state_q    <= S_RUN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_addr = pix_addr_q;
  assign wgt_addr = wgt_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign LED      = {busy_q, 2'b00, valid_q, digit_q};

endmodule

// File: tb/tb_digit_classify_ctrl.sv
// tb/tb_digit_classify_ctrl.sv - directed self-checking bench for digit_classify_ctrl
// Image RAM and weight ROM are modelled as one-cycle synchronous reads.
module tb_digit_classify_ctrl;

  logic        clk;
  logic        rst_n;
  logic        switch;
  logic [9:0]  pix_addr;
  logic [7:0]  pix_data;
  logic [12:0] wgt_addr;
  logic [7:0]  wgt_data;
  logic        busy;
  logic        done;
  logic [7:0]  LED;

  int checks;
  int passes;

  logic [7:0] img [0:3];
  logic [7:0] wrom [0:63];
  int pa_log [0:60];
  int wa_log [0:60];

  digit_classify_ctrl #(
    .NUM_PIXELS (4),
    .NUM_CLASSES(10),
    .PIX_AW     (10),
    .WGT_AW     (13),
    .ACC_W      (24)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .switch  (switch),
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .wgt_addr(wgt_addr),
    .wgt_data(wgt_data),
    .busy    (busy),
    .done    (done),
    .LED     (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pix_data <= img[pix_addr[1:0]];
    wgt_data <= wrom[wgt_addr[5:0]];
  end

  task automatic set_pixels(input logic [7:0] v);
    for (int p = 0; p < 4; p++) img[p] = v;
  endtask

  task automatic set_class(input int c, input logic [7:0] w);
    for (int p = 0; p < 4; p++) wrom[c*4+p] = w;
  endtask

  task automatic set_max_weights();
    for (int c = 0; c < 10; c++) set_class(c, (c == 7) ? 8'd20 : 8'(c));
  endtask

  // Raises switch, returns cycles until busy and the done cycle counted from the accept cycle (= 0).
  task automatic do_run(output int busy_lat, output int done_lat, output logic [7:0] led_at_start);
    int n;
    n = 0;
    @(negedge clk);
    switch = 1'b1;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    busy_lat     = n;
    led_at_start = LED;
    done_lat     = 1;
    while (!done && done_lat < 200) begin
      if (done_lat <= 60) begin
        pa_log[done_lat] = int'(pix_addr);
        wa_log[done_lat] = int'(wgt_addr);
      end
      @(negedge clk);
      done_lat++;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    switch = 1'b0;
    for (int p = 0; p < 64; p++) wrom[p] = 8'd0;
    set_pixels(8'd0);
    repeat (3) @(negedge clk);
    checks++; if (LED !== 8'h00) $display("FAIL reset_led got %h want 00", LED); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (pix_addr !== 10'd0) $display("FAIL reset_pix_addr got %0d want 0", pix_addr); else passes++;
    checks++; if (wgt_addr !== 13'd0) $display("FAIL reset_wgt_addr got %0d want 0", wgt_addr); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_max_and_addr();
    int bl, dl, bad, first_i;
    logic [7:0] ls;
    set_pixels(8'd1);
    set_max_weights();
    do_run(bl, dl, ls);
    checks++; if (bl !== 3) $display("FAIL start_latency got %0d want 3", bl); else passes++;
    checks++; if (dl !== 61) $display("FAIL done_latency got %0d want 61", dl); else passes++;
    checks++; if (ls !== 8'h80) $display("FAIL max_led_start got %h want 80", ls); else passes++;
    checks++; if (LED !== 8'h17) $display("FAIL max_led got %h want 17", LED); else passes++;
    checks++; if (dut.best_score_q !== 24'sd80) $display("FAIL max_best got %0d want 80", $signed(dut.best_score_q)); else passes++;
    bad = 0; first_i = 0;
    for (int i = 1; i <= 60; i++) begin
      int k, r, p;
      k = (i - 1) / 6;
      r = (i - 1) % 6;
      p = (r < 4) ? r : 3;
      if (pa_log[i] != p || wa_log[i] != k*4 + p) begin
        if (bad == 0) first_i = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL addr_seq got %0d bad cycles (first cycle %0d pix %0d wgt %0d) want 0", bad, first_i, pa_log[first_i], wa_log[first_i]);
    else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL done_pulse got %b want 0", done); else passes++;
    checks++; if (LED !== 8'h17) $display("FAIL led_hold got %h want 17", LED); else passes++;
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_weights();
    int bl, dl;
    logic [7:0] ls;
    set_pixels(8'd9);
    for (int c = 0; c < 10; c++) set_class(c, 8'd0);
    do_run(bl, dl, ls);
    checks++; if (ls !== 8'h87) $display("FAIL zero_led_start got %h want 87", ls); else passes++;
    checks++; if (dl !== 61) $display("FAIL zero_latency got %0d want 61", dl); else passes++;
    checks++; if (LED !== 8'h10) $display("FAIL zero_led got %h want 10", LED); else passes++;
    checks++; if (dut.best_score_q !== 24'sd0) $display("FAIL zero_best got %0d want 0", $signed(dut.best_score_q)); else passes++;
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_negative();
    int bl, dl;
    logic [7:0] ls;
    set_pixels(8'd255);
    for (int c = 0; c < 10; c++) set_class(c, (c == 3) ? 8'hFF : 8'(-(10 - c)));
    do_run(bl, dl, ls);
    checks++; if (LED !== 8'h13) $display("FAIL neg_led got %h want 13", LED); else passes++;
    checks++; if (dut.best_score_q !== -24'sd1020) $display("FAIL neg_best got %0d want -1020", $signed(dut.best_score_q)); else passes++;
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_switch_held();
    int dones;
    bit seen;
    dones = 0;
    seen  = 1'b0;
    set_pixels(8'd1);
    set_max_weights();
    @(negedge clk);
    switch = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 30) switch = 1'b0;
      if (i == 33) switch = 1'b1;
      if (busy && !seen) begin
        seen = 1'b1;
        checks++; if (LED !== 8'h83) $display("FAIL rerun_led_start got %h want 83", LED); else passes++;
      end
      if (done) dones++;
    end
    checks++; if (dones !== 1) $display("FAIL held_done_count got %0d want 1", dones); else passes++;
    checks++; if (LED !== 8'h17) $display("FAIL held_led got %h want 17", LED); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL held_busy got %b want 0", busy); else passes++;
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n, dones, bl, dl;
    logic [7:0] ls;
    n = 0;
    dones = 0;
    set_max_weights();
    @(negedge clk);
    switch = 1'b1;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    // First busy cycle is cycle 1; cycle 32 is class 5, pixel 1.
    repeat (31) @(negedge clk);
    checks++; if (wgt_addr !== 13'd21) $display("FAIL mid_wgt_addr got %0d want 21", wgt_addr); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (LED !== 8'h00) $display("FAIL mid_reset_led got %h want 00", LED); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else passes++;
    checks++; if (wgt_addr !== 13'd0) $display("FAIL mid_reset_wgt_addr got %0d want 0", wgt_addr); else passes++;
    switch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL mid_reset_done got %0d want 0", dones); else passes++;
    do_run(bl, dl, ls);
    checks++; if (dl !== 61) $display("FAIL after_reset_latency got %0d want 61", dl); else passes++;
    checks++; if (LED !== 8'h17) $display("FAIL after_reset_led got %h want 17", LED); else passes++;
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_max_and_addr();
    test_zero_weights();
    test_negative();
    test_switch_held();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/digit_classify_ctrl.md
Name: digit_classify_ctrl

Overview:
Sequencer for the digit-recognizer datapath. On a rising edge of the board switch it walks every class and every pixel, issues read addresses to the image RAM and weight ROM, and accumulates pixel × weight dot products. It tracks the argmax across classes and presents the recognized digit on the LEDs. It sits between the top-level finalproject pins (clk, switch, LED) and the memories.

Parameters:
NUM_PIXELS, 784, pixels per image (bench uses 4)
NUM_CLASSES, 10, digit classes
PIX_AW, 10, pixel address width, ≥ clog2(NUM_PIXELS)
WGT_AW, 13, weight address width, ≥ clog2(NUM_PIXELS*NUM_CLASSES)
ACC_W, 24, signed accumulator width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
switch  in  1  asynchronous start switch; a rising edge starts a run
pix_addr  out  PIX_AW  image RAM read address
pix_data  in  8  unsigned pixel; valid 1 cycle after pix_addr
wgt_addr  out  WGT_AW  weight ROM address = class*NUM_PIXELS + pixel
wgt_data  in  8  signed weight; valid 1 cycle after wgt_addr
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when the result is written
LED  out  8  [3:0] digit, [4] result valid, [7] busy, [6:5] 0

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0; acc, best_score, best_idx, counters and synchronizer all 0.
- Switch: 2-flop synchronizer, then an edge register. start = sync_q & ~edge_q.
  - start is accepted only in IDLE or DONE. It is ignored while busy.
  - A switch held high gives one run only.
- States: IDLE, RUN, DRAIN, CMP, DONE.
- IDLE/DONE, on start: class=0, pix=0, acc=0, LED[4]=0. LED[3:0] holds the previous digit. busy=1. Next state is RUN.
- RUN, one cycle per pixel:
  - Drive pix_addr=pix and wgt_addr=class*NUM_PIXELS+pix.
  - rd_valid (registered) marks that data from the previous cycle's address is present.
  - When rd_valid: acc <= acc + sext({1'b0,pix_data}) * sext(wgt_data), computed at ACC_W. Wraps modulo 2^ACC_W, no saturation.
  - pix++. At pix==NUM_PIXELS-1 go to DRAIN.
- DRAIN: accumulate the last pixel's data, then go to CMP. Address outputs hold their last value.
- CMP:
  - If class==0 or acc > best_score (signed, strict): best_score<=acc, best_idx<=class.
  - Ties keep the lower class index.
  - acc<=0, pix<=0.
  - If class==NUM_CLASSES-1 go to DONE; otherwise class++ and go to RUN.
- Entering DONE: LED[3:0]<=best_idx, LED[4]<=1, done=1 for one cycle, busy=0. DONE behaves as IDLE for start.
- Latency: each class takes NUM_PIXELS+2 cycles. done asserts NUM_CLASSES*(NUM_PIXELS+2)+1 cycles after the start-accept cycle.
- Switch to start: start asserts 3 clk edges after switch rises (synchronizer plus edge detect).
- Reset mid-run: immediate abort. All outputs return to 0 and no done pulse is produced.
- Switch falling edge: no effect.
- Address outputs are registered. They are 0 in IDLE and hold their last value in DONE.

Test Plan:
- NUM_PIXELS=4, all pixels=1, weights: class c = c, except class 7 = 20 -> LED=8'h17 after done, best_score=80. done asserts exactly 61 cycles after start accept.
- All weights 0 -> ties everywhere -> LED[3:0]=0, LED[4]=1.
- Pixels=255, all weights negative: class c = -(10-c), except class 3 = -1 -> digit 3, best_score=-1020. Checks signed compare and sign extension.
- Check wgt_addr sequence 0,1,2,3, 4,5,6,7, …, 36..39, with pix_addr cycling 0..3 and no gaps. No addresses are issued in DRAIN or CMP.
- Switch held high through two full runs -> exactly one done. A second rise during busy is ignored. A rise after done starts a new run, which clears LED[4] and leaves LED[3:0] unchanged until the new done.
- Pull rst_n low mid-RUN (class 5) -> LED=0, busy=0 immediately, no done. A subsequent switch rise gives a correct full run.
